// File: rtl/sfu_pkg.sv
// Shared SFU definitions: FP16 word constants and the vector packer state encoding.
package sfu_pkg;

    localparam int FP16_W = 16;
    localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

    typedef enum logic {
        FILL    = 1'b0,
        PENDING = 1'b1
    } pack_state_t;

endpackage

// File: rtl/fp16_vec_packer.sv
// Packs N consecutive FP16 stream words into one N*16-bit vector for the add tree; lane 0 = first beat.
// Optional macro PACK_TLAST_PAD_EN: s_tlast closes a vector early (zero-padded) and drives m_tlast.
module fp16_vec_packer
    import sfu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [FP16_W-1:0]     s_tdata,
    input  logic                  s_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [N*FP16_W-1:0]   m_tdata,
    output logic                  m_tlast
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int VEC_W = N * FP16_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [VEC_W-1:0] VEC_CLEAR = {N{FP16_ZERO}};

    pack_state_t          state;
    logic [IDX_W-1:0]     idx;
    logic [VEC_W-1:0]     asm_q;
    logic [VEC_W-1:0]     asm_next;
    logic                 pend_last;
    logic                 accept;
    logic                 complete;
    logic                 last_c;
    logic                 slot_free;
    logic                 handshake;

    assign accept    = s_tvalid && s_tready;
    assign handshake = m_tvalid && m_tready;
    assign slot_free = !m_tvalid || m_tready;

`ifdef PACK_TLAST_PAD_EN
    assign last_c = accept && s_tlast;
`else
    logic unused_tlast;
    assign unused_tlast = s_tlast;
    assign last_c       = 1'b0;
`endif

    assign complete = accept && ((idx == LAST_IDX) || last_c);

    // The completing word is merged here so it can go straight to the output register.
    always_comb begin
        asm_next = asm_q;
        if (accept) begin
            asm_next[idx*FP16_W +: FP16_W] = s_tdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FILL;
            idx       <= '0;
            asm_q     <= VEC_CLEAR;
            pend_last <= 1'b0;
            s_tready  <= 1'b0;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_tlast   <= 1'b0;
        end else if (state == FILL) begin
            s_tready <= 1'b1;
            if (accept) begin
                idx <= complete ? '0 : idx + 1'b1;
            end
            if (complete && slot_free) begin
                m_tdata  <= asm_next;
                m_tlast  <= last_c;
                m_tvalid <= 1'b1;
                asm_q    <= VEC_CLEAR;
            end else if (complete) begin
                // Output busy: park the finished vector in the assembly buffer and stall input.
                asm_q     <= asm_next;
                pend_last <= last_c;
                state     <= PENDING;
                s_tready  <= 1'b0;
            end else begin
                if (accept) begin
                    asm_q <= asm_next;
                end
                if (handshake) begin
                    m_tvalid <= 1'b0;
                end
            end
        end else begin
            if (m_tready) begin
                m_tdata  <= asm_q;
                m_tlast  <= pend_last;
                m_tvalid <= 1'b1;
                asm_q    <= VEC_CLEAR;
                state    <= FILL;
                s_tready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp16_vec_packer.sv
// Self-checking bench for fp16_vec_packer (N=4): vector table, backpressure, overlap, tlast and reset cases.
module tb_fp16_vec_packer;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_tvalid;
    logic          s_tready;
    logic [15:0]   s_tdata;
    logic          s_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [63:0]   m_tdata;
    logic          m_tlast;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [15:0] w [4];
        logic [63:0] vec;
    } vec_rec_t;

    exp_t     sb[$];
    vec_rec_t tbl [3];

    fp16_vec_packer #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every valid output cycle must show the oldest outstanding vector.
    always @(negedge clk) begin
        if (rst && m_tvalid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_vector actual=%h required=none", m_tdata);
            end else begin
                chk("m_tdata", m_tdata, sb[0].data);
                chk("m_tlast", 64'(m_tlast), 64'(sb[0].last));
                if (m_tready) void'(sb.pop_front());
            end
        end
    end

    task automatic send(input logic [15:0] w, input logic l);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = w;
        s_tlast  = l;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = s_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=stalled required=accept word=%h", w);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic expect_vec(input logic [63:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c0;
        logic exp_last;

        tbl[0].w = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400}; tbl[0].vec = 64'h4400_4200_4000_3C00;
        tbl[1].w = '{16'h7C00, 16'hFC00, 16'h7E00, 16'h0001}; tbl[1].vec = 64'h0001_7E00_FC00_7C00;
        tbl[2].w = '{16'h8000, 16'hBC00, 16'hFFFF, 16'h1234}; tbl[2].vec = 64'h1234_FFFF_BC00_8000;

        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tdata",  m_tdata,        64'd0);
        chk("rst_m_tlast",  64'(m_tlast),  64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("tready_before_first_edge", 64'(s_tready), 64'd0);
        @(posedge clk);
        #1;
        chk("tready_after_first_edge", 64'(s_tready), 64'd1);

        // Continuous packing, back-to-back vectors.
        c0 = cyc;
        for (int unsigned i = 0; i < 3; i++) begin
            expect_vec(tbl[i].vec, 1'b0);
            for (int unsigned j = 0; j < 4; j++) send(tbl[i].w[j], 1'b0);
            chk("latency_valid", 64'(m_tvalid), 64'd1);
        end
        chk("throughput_cycles", 64'(cyc - c0), 64'd12);
        @(posedge clk);
        #1;
        chk("idle_valid_clear", 64'(m_tvalid), 64'd0);
        chk("idle_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure: second vector goes PENDING.
        m_tready = 1'b0;
        expect_vec(64'h1111_2222_3333_4444, 1'b0);
        send(16'h4444, 1'b0); send(16'h3333, 1'b0); send(16'h2222, 1'b0); send(16'h1111, 1'b0);
        expect_vec(64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
        send(16'hDDDD, 1'b0); send(16'hCCCC, 1'b0); send(16'hBBBB, 1'b0); send(16'hAAAA, 1'b0);
        chk("pending_tready_low", 64'(s_tready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("pending_hold_tready", 64'(s_tready), 64'd0);
        chk("pending_hold_valid",  64'(m_tvalid), 64'd1);
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        chk("pending_release_tready", 64'(s_tready), 64'd1);
        chk("pending_second_valid",   64'(m_tvalid), 64'd1);
        @(posedge clk);
        #1;
        chk("pending_drained_valid", 64'(m_tvalid), 64'd0);
        chk("pending_drained_sb",    64'(sb.size()), 64'd0);

        // Completion coinciding with output handshake.
        m_tready = 1'b0;
        expect_vec(64'h0102_0304_0506_0708, 1'b0);
        send(16'h0708, 1'b0); send(16'h0506, 1'b0); send(16'h0304, 1'b0); send(16'h0102, 1'b0);
        expect_vec(64'h5A5A_A5A5_0F0F_F0F0, 1'b0);
        send(16'hF0F0, 1'b0); send(16'h0F0F, 1'b0); send(16'hA5A5, 1'b0);
        m_tready = 1'b1;
        c0 = cyc;
        send(16'h5A5A, 1'b0);
        chk("overlap_no_stall", 64'(cyc - c0), 64'd1);
        chk("overlap_valid",    64'(m_tvalid), 64'd1);
        chk("overlap_tready",   64'(s_tready), 64'd1);
        drain("overlap_drain");

        // s_tlast handling.
`ifdef PACK_TLAST_PAD_EN
        expect_vec(64'h0000_0000_4000_3C00, 1'b1);
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b1);
        chk("pad_valid", 64'(m_tvalid), 64'd1);
        exp_last = 1'b1;
`else
        expect_vec(64'h4400_4200_4000_3C00, 1'b0);
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b1);
        @(negedge clk);
        chk("tlast_ignored_no_valid", 64'(m_tvalid), 64'd0);
        @(posedge clk);
        #1;
        send(16'h4200, 1'b0);
        send(16'h4400, 1'b0);
        chk("tlast_ignored_valid", 64'(m_tvalid), 64'd1);
        exp_last = 1'b0;
`endif
        expect_vec(64'h4B00_4A00_4900_4800, exp_last);
        send(16'h4800, 1'b0); send(16'h4900, 1'b0); send(16'h4A00, 1'b0); send(16'h4B00, 1'b1);
        drain("tlast_drain");

        // Reset in the middle of a vector with an output held.
        m_tready = 1'b0;
        expect_vec(tbl[1].vec, 1'b0);
        for (int unsigned j = 0; j < 4; j++) send(tbl[1].w[j], 1'b0);
        send(16'h5555, 1'b0);
        send(16'h6666, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("midrst_m_tdata",  m_tdata,        64'd0);
        chk("midrst_m_tlast",  64'(m_tlast),  64'd0);
        chk("midrst_s_tready", 64'(s_tready), 64'd0);
        sb.delete();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_tready", 64'(s_tready), 64'd1);
        chk("postrst_valid",  64'(m_tvalid), 64'd0);
        m_tready = 1'b1;
        expect_vec(tbl[2].vec, 1'b0);
        for (int unsigned j = 0; j < 4; j++) send(tbl[2].w[j], 1'b0);
        chk("postrst_vec_valid", 64'(m_tvalid), 64'd1);
        drain("postrst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
